// File: rtl/timer_sched_pkg.sv
// Shared definitions for the interval-timer scheduler: sequencer states,
// the timer's tick scaling and the default interval width.
package timer_sched_pkg;

  // Width of the timer's interval register (milliseconds)
  localparam int IW_DEFAULT = 16;

  // The timer counts 2**13 ticks per millisecond of interval
  localparam int TICKS_PER_MS_LOG2 = 13;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_ARM   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_DRAIN = 3'd5
  } state_t;

endpackage

// File: rtl/timer_sched_rr_arbiter.sv
// Combinational round-robin pick: the first set request found when scanning
// upwards from ptr, wrapping at N.
module timer_sched_rr_arbiter #(
  parameter int N    = 4,
  parameter int IDXW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic            valid,
  output logic [IDXW-1:0] idx
);

  logic [IDXW-1:0] pos;

  // Walk the scan order backwards so the closest requester to ptr is the last to write idx
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = IDXW'((int'(ptr) + k) % N);
      if (req[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/timer_sched.sv
// Shares one interval timer among N_REQ requesters: arbitrates round-robin,
// programs the interval, re-arms the timer via its status read, waits for
// expiry and pulses done to the winner. Requesters may cancel while waiting.
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = IW_DEFAULT
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               GWE,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*IW-1:0] req_interval,
  output logic [N_REQ-1:0]   done,
  output logic               busy,
  output logic [2:0]         grant_id,
  output logic               tmr_write_interval,
  output logic [IW-1:0]      tmr_interval,
  output logic               tmr_read_status,
  input  logic               tmr_status
);

  localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t          state;
  logic [IDXW-1:0] rr_ptr;
  logic [IDXW-1:0] gnt_q;
  logic [IW-1:0]   interval_q;
  logic            arb_valid;
  logic [IDXW-1:0] arb_idx;
  logic [IW-1:0]   sel_interval;
  logic [IDXW-1:0] next_ptr;

  timer_sched_rr_arbiter #(
    .N    (N_REQ),
    .IDXW (IDXW)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  // Select the interval belonging to the arbiter's current winner
  always_comb begin
    sel_interval = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (int'(arb_idx) == i) sel_interval = req_interval[i*IW +: IW];
    end
  end

  // Fairness pointer moves to the requester just after the one finishing now
  always_comb begin
    next_ptr = gnt_q + 1'b1;
    if (int'(gnt_q) == N_REQ - 1) next_ptr = '0;
  end

  // Sequencer: write interval, re-arm on the status read, wait for expiry or cancel; frozen while GWE is low
  always_ff @(posedge CLK) begin
    if (GWE) begin
      if (RST) begin
        state      <= ST_IDLE;
        rr_ptr     <= '0;
        gnt_q      <= '0;
        interval_q <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (arb_valid) begin
              gnt_q      <= arb_idx;
              interval_q <= sel_interval;
              state      <= ST_WRITE;
            end
          end
          ST_WRITE: state <= ST_ARM;
          ST_ARM: begin
            if (tmr_status) state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (tmr_status)       state <= ST_DONE;
            else if (!req[gnt_q]) state <= ST_DRAIN;
          end
          ST_DONE: begin
            rr_ptr <= next_ptr;
            state  <= ST_IDLE;
          end
          ST_DRAIN: begin
            if (tmr_status) begin
              rr_ptr <= next_ptr;
              state  <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Outputs decode the registered state; the only input reaching them is the timer status during ARM
  always_comb begin
    done = '0;
    if (state == ST_DONE) done[gnt_q] = 1'b1;
    busy               = (state != ST_IDLE);
    tmr_write_interval = (state == ST_WRITE);
    tmr_interval       = (state == ST_WRITE) ? interval_q : '0;
    tmr_read_status    = (state == ST_ARM) && tmr_status;
  end

  assign grant_id = 3'(gnt_q);

endmodule
